// File: rtl/pc_unit.sv
// Fetch program-counter generator: sequential fetch, hazard wait states,
// privilege-aware trap redirection, mret/sret return and a wait watchdog.
module pc_unit #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              WAIT_LIMIT   = 64,
  parameter int              CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     if_inst,
  input  logic            if_valid,
  input  logic            mem_valid,
  input  logic            mmu_data_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            trap_to_s,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic            xret_valid,
  input  logic            xret_is_sret,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  output logic [XLEN-1:0] pc,
  output logic            fetch_en,
  output logic [1:0]      wait_state,
  output logic            hang_err
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    CTRL_WAIT = 2'd1,
    XRET_WAIT = 2'd2,
    TRAP_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic            hang_reg;

  logic            stall;
  logic [XLEN-1:0] tvec;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] trap_target;
  logic [6:0]      opcode;
  logic            is_ctrl;
  logic            is_xret;
  logic            is_trap;
  logic [CNT_W-1:0] cnt_next;

  assign stall = mem_valid & ~mmu_data_ready;

  always_comb begin
    tvec      = trap_to_s ? stvec : mtvec;
    tvec_base = {tvec[XLEN-1:2], 2'b00};
    // Vectored mode only applies to interrupts; 4*cause wraps at XLEN bits.
    if (tvec[1:0] == 2'b01 && trap_cause[XLEN-1])
      trap_target = tvec_base + XLEN'({trap_cause[XLEN-2:0], 2'b00});
    else
      trap_target = tvec_base;
  end

  always_comb begin
    opcode  = if_inst[6:0];
    is_ctrl = (opcode == 7'b1101111) || (opcode == 7'b1100111) ||
              (opcode == 7'b1100011);
    is_xret = (if_inst == 32'h3020_0073) || (if_inst == 32'h1020_0073);
    is_trap = (if_inst == 32'h0000_0073) || (if_inst == 32'hC000_1073);
    cnt_next = (cnt_reg == LIMIT) ? cnt_reg : cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_VECTOR;
      state_reg <= RUN;
      cnt_reg   <= '0;
      hang_reg  <= 1'b0;
    end else if (trap_valid) begin
      pc_reg    <= trap_target;
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else if (xret_valid) begin
      pc_reg    <= xret_is_sret ? sepc : mepc;
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else if (state_reg == CTRL_WAIT && redirect_valid) begin
      pc_reg    <= redirect_target;
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else if (!stall) begin
      if (state_reg == RUN) begin
        if (if_valid) begin
          if (is_ctrl)      state_reg <= CTRL_WAIT;
          else if (is_xret) state_reg <= XRET_WAIT;
          else if (is_trap) state_reg <= TRAP_WAIT;
          else              pc_reg    <= pc_reg + XLEN'(4);
        end
      end else begin
        // Watchdog only flags; recovery is left to trap/xret/redirect or reset.
        cnt_reg <= cnt_next;
        if (cnt_next == LIMIT) hang_reg <= 1'b1;
      end
    end
  end

  assign pc         = pc_reg;
  assign wait_state = state_reg;
  assign hang_err   = hang_reg;
  assign fetch_en   = (state_reg == RUN) & ~stall;

endmodule
